// File: rtl/mem_burst_adapter.sv
// -----------------------------------------------------------------------------
// mem_burst_adapter
//
// Bridges the cache's 128-bit block memory port to a 32-bit word-wide memory.
// A block read (fetch) or block write (write-back) is run as a 4-beat burst of
// word transfers with a per-beat dram_req/dram_ack handshake, and completion
// is reported to the cache with a one-cycle mem_ready pulse.
//
// Optional build macro: MEM_TIMEOUT_EN
//   When defined, each beat waits at most TIMEOUT_CYCLES for dram_ack. On
//   expiry the beat is forced complete (a read beat returns 32'h0) and the
//   sticky mem_err flag is raised. When undefined, beats wait indefinitely
//   and mem_err is tied to 0.
//
// Ports:
//   clk         rising-edge clock
//   proc_reset  synchronous active-high reset
//   mem_read    cache block-read request, held until mem_ready
//   mem_write   cache block-write request, held until mem_ready (wins ties)
//   mem_addr    cache block address
//   mem_wdata   block to write back
//   mem_rdata   fetched block, valid when mem_ready=1
//   mem_ready   one-cycle completion pulse
//   dram_req    memory word request
//   dram_we     1 = write beat, 0 = read beat
//   dram_addr   word address {latched block address, beat}
//   dram_wdata  write beat data
//   dram_rdata  read beat data, valid when dram_req && dram_ack
//   dram_ack    beat completes on any cycle with dram_req && dram_ack
//   mem_err     sticky timeout flag
// -----------------------------------------------------------------------------
module mem_burst_adapter #(
  parameter int BLOCK_WIDTH    = 128,
  parameter int WORD_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 28,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  proc_reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [BLOCK_WIDTH-1:0] mem_wdata,
  output logic [BLOCK_WIDTH-1:0] mem_rdata,
  output logic                  mem_ready,
  output logic                  dram_req,
  output logic                  dram_we,
  output logic [ADDR_WIDTH+1:0] dram_addr,
  output logic [WORD_WIDTH-1:0] dram_wdata,
  input  logic [WORD_WIDTH-1:0] dram_rdata,
  input  logic                  dram_ack,
  output logic                  mem_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [1:0]             beat;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [BLOCK_WIDTH-1:0] wdata_q;
  logic [BLOCK_WIDTH-1:0] rdata_q;

  logic in_burst;    // S_RD or S_WR: a beat is outstanding
  logic handshake;   // memory accepted/returned the current word
  logic beat_done;   // current beat retires this cycle (handshake or timeout)
  logic timeout;     // current beat gave up waiting for dram_ack

  assign in_burst  = (state == S_RD) || (state == S_WR);
  assign handshake = in_burst && dram_ack;
  assign beat_done = handshake || timeout;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  // A handshake on the expiry cycle still counts as a real handshake.
  assign timeout = in_burst && !dram_ack && (wait_cnt == TIMEOUT_MAX);

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == S_IDLE || beat_done) begin
        wait_cnt <= '0;
      end else if (in_burst) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  assign mem_err = err_q;
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  // State register and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state   <= S_IDLE;
      beat    <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          beat <= 2'd0;
          if (mem_write || mem_read) begin
            addr_q <= mem_addr;
          end
          if (mem_write) begin
            wdata_q <= mem_wdata;
          end
        end
        S_RD, S_WR: begin
          if (beat_done) begin
            beat <= beat + 2'd1;
          end
          // A timed-out read beat returns zero rather than bus garbage.
          if (state == S_RD && beat_done) begin
            rdata_q[WORD_WIDTH*int'(beat) +: WORD_WIDTH] <=
              handshake ? dram_rdata : '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (mem_write) begin
          state_next = S_WR;
        end else if (mem_read) begin
          state_next = S_RD;
        end
      end
      S_RD, S_WR: begin
        if (beat_done && beat == 2'd3) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decode directly from registered state, so they are glitch-free
  // relative to the clock and all read zero while in reset.
  assign dram_req   = in_burst;
  assign dram_we    = (state == S_WR);
  assign dram_addr  = {addr_q, beat};
  assign dram_wdata = wdata_q[WORD_WIDTH*int'(beat) +: WORD_WIDTH];
  assign mem_ready  = (state == S_DONE);
  assign mem_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_burst_adapter.sv
// -----------------------------------------------------------------------------
// tb_mem_burst_adapter
//
// Self-checking bench for mem_burst_adapter. A burst-level reference model
// predicts, per cycle, which word the adapter should present and what block
// the cache should receive, from the request and the ack/rdata pattern the
// bench drives. Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_burst_adapter;

  localparam int AW = 28;
  localparam int BW = 128;
  localparam int WW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          proc_reset;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_wdata;
  logic [BW-1:0] mem_rdata;
  logic          mem_ready;
  logic          dram_req;
  logic          dram_we;
  logic [AW+1:0] dram_addr;
  logic [WW-1:0] dram_wdata;
  logic [WW-1:0] dram_rdata;
  logic          dram_ack;
  logic          mem_err;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: block the cache last received, and the sticky error flag.
  logic [BW-1:0] model_rdata = '0;
  logic          model_err   = 1'b0;

  mem_burst_adapter #(
    .BLOCK_WIDTH   (BW),
    .WORD_WIDTH    (WW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .proc_reset(proc_reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .dram_req  (dram_req),
    .dram_we   (dram_we),
    .dram_addr (dram_addr),
    .dram_wdata(dram_wdata),
    .dram_rdata(dram_rdata),
    .dram_ack  (dram_ack),
    .mem_err   (mem_err)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Idle cycles with no request: the adapter must stay quiet.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      mem_read  = 1'b0;
      mem_write = 1'b0;
      dram_ack  = 1'b0;
      @(negedge clk);
      vectors++;
      if (dram_req !== 1'b0 || mem_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_quiet: dram_req=%b mem_ready=%b, want 0 0",
                 dram_req, mem_ready);
      end
    end
  endtask

  // One complete cache transaction. The request is presented on cycle 0
  // and held through the mem_ready cycle.
  //   ack_mode 0: ack every cycle; 1: ack every other cycle, wait first;
  //            2: random ack (a wait never exceeds 5 cycles)
  //   addr_data: read data is the word address, else random
  //   stuck_beat: beat whose ack never comes (-1 for none)
  task automatic run_burst(input bit wr, input bit rd,
                           input logic [AW-1:0] addr,
                           input logic [BW-1:0] wdata,
                           input int ack_mode, input bit addr_data,
                           input int stuck_beat);
    int            beat  = 0;
    int            waits = 0;
    int            cyc   = 0;
    bit            ack;
    bit            tmo;
    logic [1:0]    b;
    logic [WW-1:0] word;
    logic [WW-1:0] exp_wword;
    logic [BW-1:0] blk;
    bit            is_wr;
    is_wr = wr;               // write wins a simultaneous request
    blk   = model_rdata;

    next_cycle();
    mem_write = wr;
    mem_read  = rd;
    mem_addr  = addr;
    mem_wdata = wdata;
    dram_ack  = 1'b0;
    @(negedge clk);
    vectors++;
    if (dram_req !== 1'b0 || mem_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL req_cycle0: dram_req=%b mem_ready=%b, want 0 0",
               dram_req, mem_ready);
    end

    while (beat < 4) begin
      next_cycle();
      // Only the latched copies may matter once the burst is under way.
      mem_addr  = AW'($urandom);
      mem_wdata = {$urandom, $urandom, $urandom, $urandom};
      b = 2'(beat);
      case (ack_mode)
        0:       ack = 1'b1;
        1:       ack = (cyc % 2 == 1);
        default: ack = ($urandom_range(0, 2) != 0) || (waits >= 5);
      endcase
      if (beat == stuck_beat) ack = 1'b0;
      word = addr_data ? WW'({2'b00, addr, b}) : WW'($urandom);
      dram_ack   = ack;
      dram_rdata = word;
      exp_wword  = wdata[WW*beat +: WW];
      @(negedge clk);
      vectors++;
      if (dram_req !== 1'b1 || dram_we !== is_wr || mem_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL beat_ctrl: beat %0d req=%b we=%b ready=%b, want 1 %b 0",
                 beat, dram_req, dram_we, mem_ready, is_wr);
      end
      vectors++;
      if (dram_addr !== {addr, b}) begin
        miscompares++;
        $display("FAIL beat_addr: beat %0d got %h want %h",
                 beat, dram_addr, {addr, b});
      end
      if (is_wr) begin
        vectors++;
        if (dram_wdata !== exp_wword) begin
          miscompares++;
          $display("FAIL beat_wdata: beat %0d got %h want %h",
                   beat, dram_wdata, exp_wword);
        end
      end
      tmo = 1'b0;
`ifdef MEM_TIMEOUT_EN
      if (!ack && waits == TO) tmo = 1'b1;
`endif
      if (ack || tmo) begin
        if (!is_wr) blk[WW*beat +: WW] = ack ? word : '0;
        if (tmo) model_err = 1'b1;
        beat++;
        waits = 0;
      end else begin
        waits++;
      end
      cyc++;
      if (cyc > 400) begin
        miscompares++;
        $display("FAIL burst_budget: beat %0d still pending after %0d cycles",
                 beat, cyc);
        break;
      end
    end

    next_cycle();
    dram_ack = 1'b0;
    if (!is_wr) model_rdata = blk;
    @(negedge clk);
    vectors++;
    if (mem_ready !== 1'b1 || dram_req !== 1'b0) begin
      miscompares++;
      $display("FAIL done_ctrl: mem_ready=%b dram_req=%b, want 1 0",
               mem_ready, dram_req);
    end
    vectors++;
    if (mem_rdata !== model_rdata) begin
      miscompares++;
      $display("FAIL done_rdata: got %h want %h", mem_rdata, model_rdata);
    end
    vectors++;
    if (mem_err !== model_err) begin
      miscompares++;
      $display("FAIL done_err: got %b want %b", mem_err, model_err);
    end
  endtask

  task automatic test_reset();
    proc_reset = 1'b1;
    mem_read   = 1'b1;
    mem_write  = 1'b1;
    mem_addr   = AW'($urandom);
    mem_wdata  = {$urandom, $urandom, $urandom, $urandom};
    dram_ack   = 1'b1;
    dram_rdata = $urandom;
    repeat (2) next_cycle();
    @(negedge clk);
    vectors++;
    if (dram_req !== 1'b0 || dram_we !== 1'b0 || mem_ready !== 1'b0 ||
        dram_addr !== '0 || dram_wdata !== '0 || mem_rdata !== '0 ||
        mem_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: req=%b we=%b rdy=%b addr=%h wd=%h rd=%h err=%b, want all 0",
               dram_req, dram_we, mem_ready, dram_addr, dram_wdata, mem_rdata, mem_err);
    end
    next_cycle();
    proc_reset = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    dram_ack   = 1'b0;
    model_rdata = '0;
    model_err   = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_read_ack_high();
    run_burst(1'b0, 1'b1, 28'h0000123, '0, 0, 1'b1, -1);
    vectors++;
    if (model_rdata !== 128'h0000048F_0000048E_0000048D_0000048C) begin
      miscompares++;
      $display("FAIL read_directed_block: model %h", model_rdata);
    end
    idle_cycles(1);
  endtask

  task automatic test_write_waits();
    run_burst(1'b1, 1'b0, AW'($urandom),
              128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1, 1'b0, -1);
    idle_cycles(1);
  endtask

  task automatic test_back_to_back();
    run_burst(1'b1, 1'b0, AW'($urandom),
              {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, -1);
    run_burst(1'b0, 1'b1, AW'($urandom), '0, 2, 1'b0, -1);
    idle_cycles(3);
  endtask

  task automatic test_reset_mid_burst();
    next_cycle();
    mem_read  = 1'b1;
    mem_write = 1'b0;
    mem_addr  = AW'($urandom);
    dram_ack  = 1'b1;
    next_cycle();                 // beat 0
    dram_rdata = $urandom;
    next_cycle();                 // beat 1
    dram_rdata = $urandom;
    next_cycle();                 // beat 2, reset sampled at its end
    proc_reset = 1'b1;
    next_cycle();
    proc_reset = 1'b0;
    mem_read   = 1'b0;
    dram_ack   = 1'b0;
    model_rdata = '0;
    model_err   = 1'b0;
    @(negedge clk);
    vectors++;
    if (dram_req !== 1'b0 || mem_ready !== 1'b0 || mem_rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_abort: req=%b ready=%b rdata=%h, want 0 0 0",
               dram_req, mem_ready, mem_rdata);
    end
    idle_cycles(4);
    run_burst(1'b0, 1'b1, AW'($urandom), '0, 2, 1'b0, -1);
    idle_cycles(1);
  endtask

  task automatic test_simultaneous();
    run_burst(1'b1, 1'b1, AW'($urandom),
              {$urandom, $urandom, $urandom, $urandom}, 2, 1'b0, -1);
    idle_cycles(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      bit wr;
      wr = 1'($urandom);
      run_burst(wr, !wr, AW'($urandom),
                {$urandom, $urandom, $urandom, $urandom}, 2, 1'b0, -1);
      if ($urandom_range(0, 1) == 0) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(1);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    run_burst(1'b0, 1'b1, AW'($urandom), '0, 0, 1'b0, 1);
    vectors++;
    if (mem_rdata[63:32] !== 32'h0) begin
      miscompares++;
      $display("FAIL timeout_word: got %h want 00000000", mem_rdata[63:32]);
    end
    idle_cycles(3);
    run_burst(1'b1, 1'b0, AW'($urandom),
              {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, -1);
    test_reset();
  endtask
`endif

  initial begin
    proc_reset = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    dram_ack   = 1'b0;
    dram_rdata = '0;
    test_reset();
    test_read_ack_high();
    test_write_waits();
    test_back_to_back();
    test_reset_mid_burst();
    test_simultaneous();
    test_random();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_burst_adapter.md
Name: mem_burst_adapter

Overview:
- Sits directly downstream of the data/instruction cache, between the cache's 128-bit block memory port and a narrower 32-bit word-wide memory.
- Accepts one block read (fetch) or block write (write-back) request from the cache.
- Runs it as a 4-beat burst of 32-bit word transfers on the memory side, with a per-beat req/ack handshake.
- Returns a one-cycle mem_ready pulse to the cache when the whole block is done.

Parameters:
BLOCK_WIDTH, 128, cache block width in bits
WORD_WIDTH, 32, memory-side data width in bits; BLOCK_WIDTH/WORD_WIDTH = 4 beats (fixed)
ADDR_WIDTH, 28, cache-side block address width
TIMEOUT_CYCLES, 255, max wait per beat for dram_ack (used only with MEM_TIMEOUT_EN)

Ports:
clk  input  1  clock, all logic on rising edge
proc_reset  input  1  synchronous active-high reset
mem_read  input  1  cache block-read request, held until mem_ready
mem_write  input  1  cache block-write request, held until mem_ready
mem_addr  input  28  cache block address
mem_wdata  input  128  block to write back
mem_rdata  output  128  fetched block, valid when mem_ready=1
mem_ready  output  1  one-cycle completion pulse
dram_req  output  1  memory word request
dram_we  output  1  1=write beat, 0=read beat
dram_addr  output  30  word address = {latched mem_addr, beat[1:0]}
dram_wdata  output  32  write beat data
dram_rdata  input  32  read beat data, valid when dram_req && dram_ack
dram_ack  input  1  beat completes on any cycle with dram_req && dram_ack
mem_err  output  1  sticky timeout flag (MEM_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset (proc_reset=1 at a clk edge) values:
  - state=S_IDLE, beat=0.
  - mem_ready=0, mem_rdata=0.
  - dram_req=0, dram_we=0, dram_addr=0, dram_wdata=0.
  - mem_err=0.
  - Reset mid-burst aborts the burst: dram_req is low the cycle after reset is sampled, and no mem_ready is issued.
- States are S_IDLE, S_RD, S_WR, S_DONE.
- S_IDLE:
  - If mem_write=1, latch mem_addr and mem_wdata, beat=0, go to S_WR.
  - Else if mem_read=1, latch mem_addr, beat=0, go to S_RD.
  - If both are high, write wins; the cache never does this, but the behaviour is defined.
- S_RD / S_WR:
  - dram_req=1 throughout. dram_we=1 only in S_WR.
  - dram_addr = {addr_latched, beat}. dram_wdata = wdata_latched[32*beat +: 32].
  - On a beat handshake in S_RD, capture dram_rdata into mem_rdata[32*beat +: 32].
  - On a beat handshake, beat increments; dram_addr and dram_wdata advance the next cycle, with dram_req staying high.
  - A handshake on beat 3 moves the block to S_DONE; dram_req=0 in S_DONE.
- S_DONE:
  - mem_ready=1 for exactly this one cycle, then the block returns to S_IDLE.
  - mem_rdata holds the assembled block from the final beat until the next read's first beat capture; S_WR leaves mem_rdata unchanged.
- Latency:
  - Request seen at cycle 0 (S_IDLE).
  - Beats run from cycle 1.
  - With dram_ack tied high, beats complete at cycles 1–4 and mem_ready pulses at cycle 5.
  - Each wait cycle (dram_ack=0) adds one cycle.
- Back-to-back requests:
  - The cache changes its request on the edge where it samples mem_ready.
  - The S_IDLE cycle after S_DONE therefore samples the new request, e.g. a write-back followed by a fetch.
  - No stale re-trigger is possible because S_DONE never samples requests.
- Request inputs are ignored outside S_IDLE; mem_addr and mem_wdata are used only through their latched copies.
- The adapter does not drop dram_req mid-burst except on reset.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- When defined:
  - A wait counter clears on each handshake and on entry to S_RD/S_WR, and increments every S_RD/S_WR cycle without a handshake.
  - If it reaches TIMEOUT_CYCLES, mem_err is set (sticky until proc_reset), the current beat is treated as complete, and a read beat captures 32'h0.
  - The burst then proceeds, so the cache is never hung.
- When undefined:
  - The block waits for dram_ack indefinitely.
  - mem_err is constant 0 and the counter is not built.

Test Plan:
- Read, ack tied high: mem_read=1, mem_addr=28'h0000123, dram_rdata=word address → dram_addr 30'h000048C..48F on cycles 1–4, dram_we=0; mem_ready on cycle 5; mem_rdata={0000048F,0000048E,0000048D,0000048C}.
- Write with one wait cycle per beat (ack every other cycle): mem_wdata=128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA → dram_wdata sequence AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD with dram_we=1; each word held 2 cycles; mem_ready on cycle 9; mem_rdata unchanged.
- Write-back then fetch: mem_write held until mem_ready, then mem_read asserted the next cycle with a new address → exactly one write burst then one read burst; no extra burst; dram_req low for the S_DONE and S_IDLE cycles between them.
- Reset mid-burst: proc_reset=1 during read beat 2 → dram_req=0 the next cycle; mem_ready never pulses; a new read afterwards starts at beat 0 and completes normally.
- Simultaneous mem_read=1 and mem_write=1 → S_WR burst with dram_we=1.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, dram_ack stuck 0 on beat 1 of a read → mem_err rises, word 1 of mem_rdata=0, mem_ready still pulses, mem_err stays 1 until proc_reset.
